// File: rtl/jt49_pkg.sv
// jt49 shared definitions: register indices, read/use masks and the log DAC table.
package jt49_pkg;

    localparam logic [3:0] REG_NOISE_PER  = 4'd6;
    localparam logic [3:0] REG_MIXER      = 4'd7;
    localparam logic [3:0] REG_AMP_A      = 4'd8;
    localparam logic [3:0] REG_ENV_FINE   = 4'd11;
    localparam logic [3:0] REG_ENV_COARSE = 4'd12;
    localparam logic [3:0] REG_ENV_SHAPE  = 4'd13;
    localparam logic [3:0] REG_IOA        = 4'd14;
    localparam logic [3:0] REG_IOB        = 4'd15;

    localparam logic [7:0] MASK_TONE_HI = 8'h0F;
    localparam logic [7:0] MASK_NOISE   = 8'h1F;
    localparam logic [7:0] MASK_AMP     = 8'h1F;
    localparam logic [7:0] MASK_SHAPE   = 8'h0F;
    localparam logic [7:0] MASK_FULL    = 8'hFF;

    // Bits that are meaningful in each register; registers keep the raw byte.
    function automatic logic [7:0] reg_mask(input logic [3:0] idx);
        case (idx)
            4'd1, 4'd3, 4'd5:    reg_mask = MASK_TONE_HI;
            REG_NOISE_PER:       reg_mask = MASK_NOISE;
            4'd8, 4'd9, 4'd10:   reg_mask = MASK_AMP;
            REG_ENV_SHAPE:       reg_mask = MASK_SHAPE;
            default:             reg_mask = MASK_FULL;
        endcase
    endfunction

    // Roughly 1.5 dB per step, silent at 0, full scale at 31.
    function automatic logic [7:0] dac_log(input logic [4:0] idx);
        case (idx)
            5'd0:  dac_log = 8'd0;    5'd1:  dac_log = 8'd1;
            5'd2:  dac_log = 8'd1;    5'd3:  dac_log = 8'd1;
            5'd4:  dac_log = 8'd2;    5'd5:  dac_log = 8'd2;
            5'd6:  dac_log = 8'd3;    5'd7:  dac_log = 8'd3;
            5'd8:  dac_log = 8'd4;    5'd9:  dac_log = 8'd5;
            5'd10: dac_log = 8'd6;    5'd11: dac_log = 8'd7;
            5'd12: dac_log = 8'd9;    5'd13: dac_log = 8'd11;
            5'd14: dac_log = 8'd13;   5'd15: dac_log = 8'd15;
            5'd16: dac_log = 8'd18;   5'd17: dac_log = 8'd22;
            5'd18: dac_log = 8'd26;   5'd19: dac_log = 8'd31;
            5'd20: dac_log = 8'd37;   5'd21: dac_log = 8'd44;
            5'd22: dac_log = 8'd53;   5'd23: dac_log = 8'd63;
            5'd24: dac_log = 8'd75;   5'd25: dac_log = 8'd90;
            5'd26: dac_log = 8'd107;  5'd27: dac_log = 8'd128;
            5'd28: dac_log = 8'd152;  5'd29: dac_log = 8'd181;
            5'd30: dac_log = 8'd215;  default: dac_log = 8'd255;
        endcase
    endfunction

    // A fixed 4-bit amplitude sits on the odd table entries; zero stays silent.
    function automatic logic [4:0] amp_index(input logic [3:0] amp);
        amp_index = (amp == 4'd0) ? 5'd0 : {amp, 1'b1};
    endfunction

endpackage

// File: rtl/jt49_env.sv
// jt49 envelope generator: period divider, 32-step ramp and CONT/ATT/ALT/HOLD shaping.
module jt49_env (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_i,     // one pulse per 8 internal enables
    input  logic [15:0] period_i,
    input  logic [3:0]  shape_i,    // {CONT, ATT, ALT, HOLD}
    input  logic        restart_i,  // shape register being written this clk
    input  logic        att_i,      // ATT bit of the value being written
    output logic [4:0]  level_o
);

    logic [15:0] cnt_q;
    logic [4:0]  step_q;
    logic        dir_up_q;
    logic        hold_q;
    logic [15:0] per_eff;

    assign per_eff = (period_i == 16'd0) ? 16'd1 : period_i;

    // Step the ramp on each period expiry; at the end of a ramp apply the shape bits.
    // Out of reset the envelope is parked silent (up direction, step 0, held).
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= 16'd0;
            step_q   <= 5'd0;
            dir_up_q <= 1'b1;
            hold_q   <= 1'b1;
        end else if (restart_i) begin
            cnt_q    <= 16'd0;
            step_q   <= 5'd0;
            dir_up_q <= att_i;
            hold_q   <= 1'b0;
        end else if (tick_i && !hold_q) begin
            if ({1'b0, cnt_q} + 17'd1 >= {1'b0, per_eff}) begin
                cnt_q <= 16'd0;
                if (step_q == 5'd31) begin
                    if (!shape_i[3]) begin
                        step_q   <= 5'd0;
                        dir_up_q <= 1'b1;
                        hold_q   <= 1'b1;
                    end else if (shape_i[0]) begin
                        hold_q <= 1'b1;
                        if (shape_i[1]) begin
                            dir_up_q <= ~dir_up_q;
                        end
                    end else if (shape_i[1]) begin
                        dir_up_q <= ~dir_up_q;
                        step_q   <= 5'd0;
                    end else begin
                        step_q <= 5'd0;
                    end
                end else begin
                    step_q <= step_q + 5'd1;
                end
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign level_o = dir_up_q ? step_q : ~step_q;

endmodule

// File: rtl/jt49_psg.sv
// jt49 PSG top: register file, enable prescaler, tone/noise generators, mixer and log DAC.
module jt49_psg
    import jt49_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       sel,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic [3:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [7:0] C,
    output logic [9:0] sound,
    output logic       sample,
    input  logic [7:0] IOA_in,
    input  logic [7:0] IOB_in,
    output logic [7:0] IOA_out,
    output logic [7:0] IOB_out
);

    logic [7:0] regs_q [16];
    logic       wr_en;
    logic       half_q;
    logic       int_en;
    logic [2:0] pre_q;
    logic       tick;
    logic [2:0] sq;
    logic [4:0] noise_cnt_q;
    logic [4:0] noise_per;
    logic [16:0] lfsr_q;
    logic [4:0] env_level;
    logic [7:0] lvl_d [3];
    logic [7:0] lvl_q [3];
    logic [9:0] sound_q;
    logic       sample_q;

    assign wr_en = !cs_n && !wr_n;

    // Host writes land on any clk, independent of the chip clock enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 8'd0;
            end
        end else if (wr_en) begin
            regs_q[addr] <= din;
        end
    end

    // Readback: masked register, or the pin value when the port is an input.
    always_comb begin
        dout = regs_q[addr] & reg_mask(addr);
        if (addr == REG_IOA && !regs_q[REG_MIXER][6]) begin
            dout = IOA_in;
        end
        if (addr == REG_IOB && !regs_q[REG_MIXER][7]) begin
            dout = IOB_in;
        end
    end

    assign IOA_out = regs_q[REG_IOA];
    assign IOB_out = regs_q[REG_IOB];

    // Divide-by-two of the chip clock when SEL is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            half_q <= 1'b0;
        end else if (clk_en) begin
            half_q <= ~half_q;
        end
    end

    assign int_en = clk_en && (sel || half_q);

    // Shared /8 prescaler feeding tone, noise and envelope dividers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= 3'd0;
        end else if (int_en) begin
            pre_q <= pre_q + 3'd1;
        end
    end

    assign tick = int_en && (pre_q == 3'd7);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_tone
            logic [11:0] cnt_q;
            logic [11:0] period;
            logic [11:0] per_eff;
            logic        sq_q;

            assign period  = {regs_q[2*gi+1][3:0], regs_q[2*gi]};
            assign per_eff = (period == 12'd0) ? 12'd1 : period;

            // Square wave toggles each time the counter reaches the period.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= 12'd0;
                    sq_q  <= 1'b0;
                end else if (tick) begin
                    if ({1'b0, cnt_q} + 13'd1 >= {1'b0, per_eff}) begin
                        cnt_q <= 12'd0;
                        sq_q  <= ~sq_q;
                    end else begin
                        cnt_q <= cnt_q + 12'd1;
                    end
                end
            end

            assign sq[gi] = sq_q;
        end
    endgenerate

    assign noise_per = (regs_q[REG_NOISE_PER][4:0] == 5'd0) ? 5'd1 : regs_q[REG_NOISE_PER][4:0];

    // Noise LFSR shifts once per noise period expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            noise_cnt_q <= 5'd0;
            lfsr_q      <= 17'd1;
        end else if (tick) begin
            if ({1'b0, noise_cnt_q} + 6'd1 >= {1'b0, noise_per}) begin
                noise_cnt_q <= 5'd0;
                lfsr_q      <= {lfsr_q[0] ^ lfsr_q[3], lfsr_q[16:1]};
            end else begin
                noise_cnt_q <= noise_cnt_q + 5'd1;
            end
        end
    end

    jt49_env u_env (
        .clk       (clk),
        .reset     (reset),
        .tick_i    (tick),
        .period_i  ({regs_q[REG_ENV_COARSE], regs_q[REG_ENV_FINE]}),
        .shape_i   (regs_q[REG_ENV_SHAPE][3:0]),
        .restart_i (wr_en && (addr == REG_ENV_SHAPE)),
        .att_i     (din[2]),
        .level_o   (env_level)
    );

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_mix
            logic       ch_on;
            logic [4:0] amp;
            logic [4:0] idx;

            assign ch_on = (sq[gi] | regs_q[REG_MIXER][gi]) & (lfsr_q[0] | regs_q[REG_MIXER][gi+3]);
            assign amp   = regs_q[int'(REG_AMP_A) + gi][4:0];
            assign idx   = amp[4] ? env_level : amp_index(amp[3:0]);
            assign lvl_d[gi] = ch_on ? dac_log(idx) : 8'd0;
        end
    endgenerate

    // Output stage: levels, mix and sample strobe all move on the internal enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                lvl_q[i] <= 8'd0;
            end
            sound_q  <= 10'd0;
            sample_q <= 1'b0;
        end else begin
            sample_q <= int_en;
            if (int_en) begin
                for (int i = 0; i < 3; i++) begin
                    lvl_q[i] <= lvl_d[i];
                end
                sound_q <= {2'b00, lvl_d[0]} + {2'b00, lvl_d[1]} + {2'b00, lvl_d[2]};
            end
        end
    end

    assign A      = lvl_q[0];
    assign B      = lvl_q[1];
    assign C      = lvl_q[2];
    assign sound  = sound_q;
    assign sample = sample_q;

endmodule

// File: tb/tb_jt49_psg.sv
// Directed bench for jt49_psg: reset, noise seed, fixed levels, tone, envelope, masks, I/O, prescaler.
module tb_jt49_psg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_en = 1'b1;
    logic       sel = 1'b1;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic [3:0] addr = 4'd0;
    logic [7:0] din = 8'd0;
    logic [7:0] IOA_in = 8'd0;
    logic [7:0] IOB_in = 8'd0;
    logic [7:0] dout, A, B, C, IOA_out, IOB_out;
    logic [9:0] sound;
    logic       sample;

    int checks = 0;
    int passed = 0;

    localparam logic [7:0] TB_LOG [0:31] = '{
        8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3,
        8'd4, 8'd5, 8'd6, 8'd7, 8'd9, 8'd11, 8'd13, 8'd15,
        8'd18, 8'd22, 8'd26, 8'd31, 8'd37, 8'd44, 8'd53, 8'd63,
        8'd75, 8'd90, 8'd107, 8'd128, 8'd152, 8'd181, 8'd215, 8'd255
    };

    jt49_psg dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .sel(sel),
        .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din), .dout(dout),
        .A(A), .B(B), .C(C), .sound(sound), .sample(sample),
        .IOA_in(IOA_in), .IOB_in(IOB_in), .IOA_out(IOA_out), .IOB_out(IOB_out)
    );

    always #5 clk = ~clk;

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
        addr = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        $display("write R%0d = 0x%02h", a, d);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            clk_en = i[0];
            @(negedge clk);
        end
        checks++; if ({A, B, C} !== 24'd0) $display("FAIL reset_abc got %h want 0", {A, B, C}); else passed++;
        checks++; if (sound !== 10'd0) $display("FAIL reset_sound got %0d want 0", sound); else passed++;
        checks++; if (sample !== 1'b0) $display("FAIL reset_sample got %b want 0", sample); else passed++;
        checks++; if ({IOA_out, IOB_out} !== 16'd0) $display("FAIL reset_io got %h want 0", {IOA_out, IOB_out}); else passed++;
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); #1;
            checks++; if (dout !== 8'd0) $display("FAIL reset_dout R%0d got %h want 00", a, dout); else passed++;
        end
        @(negedge clk);
        reset = 1'b0; clk_en = 1'b1;
    endtask

    // LFSR seed 1 gives noise bit 1 until the first shift at the 8th enable.
    task automatic test_noise();
        sel = 1'b1; clk_en = 1'b1; reset = 1'b1;
        wait_neg(2);
        reset = 1'b0;
        write_reg(4'd7, 8'h37);
        write_reg(4'd8, 8'h0F);
        wait_neg(2);
        checks++; if (A !== 8'd255) $display("FAIL noise_seed got %0d want 255", A); else passed++;
        wait_neg(16);
        checks++; if (A !== 8'd0) $display("FAIL noise_shift got %0d want 0", A); else passed++;
        write_reg(4'd7, 8'h3F);
        write_reg(4'd8, 8'h00);
    endtask

    task automatic test_fixed_level();
        logic [7:0] amps [5] = '{8'h00, 8'h01, 8'h05, 8'h08, 8'h0F};
        logic [7:0] exps [5] = '{8'd0, 8'd1, 8'd7, 8'd22, 8'd255};
        write_reg(4'd7, 8'h3F);
        write_reg(4'd8, 8'h0F);
        wait_neg(2);
        checks++; if (A !== 8'd255) $display("FAIL fixed_A got %0d want 255", A); else passed++;
        checks++; if (sound !== 10'd255) $display("FAIL fixed_sound1 got %0d want 255", sound); else passed++;
        checks++; if (sample !== 1'b1) $display("FAIL fixed_sample got %b want 1", sample); else passed++;
        write_reg(4'd9, 8'h0F);
        wait_neg(2);
        checks++; if (B !== 8'd255) $display("FAIL fixed_B got %0d want 255", B); else passed++;
        checks++; if (sound !== 10'd510) $display("FAIL fixed_sound2 got %0d want 510", sound); else passed++;
        for (int i = 0; i < 5; i++) begin
            write_reg(4'd10, amps[i]);
            wait_neg(2);
            checks++; if (C !== exps[i]) $display("FAIL amp_C%0h got %0d want %0d", amps[i], C, exps[i]); else passed++;
            checks++; if (sound !== 10'd510 + {2'b00, exps[i]})
                $display("FAIL amp_sound%0h got %0d want %0d", amps[i], sound, 510 + exps[i]); else passed++;
        end
        write_reg(4'd9, 8'h00);
        write_reg(4'd10, 8'h00);
    endtask

    task automatic test_tone();
        int tps [3] = '{1, 3, 0};
        int halves [3] = '{8, 24, 8};
        write_reg(4'd8, 8'h0F);
        write_reg(4'd1, 8'h00);
        write_reg(4'd7, 8'h3E);
        for (int v = 0; v < 3; v++) begin
            int half;
            int k;
            int bad;
            logic [7:0] prev, first, exp;
            half = halves[v];
            write_reg(4'd0, 8'(tps[v]));
            wait_neg(2 * half + 4);
            prev = A; k = 0;
            while (A === prev && k < 2 * half + 4) begin
                @(negedge clk); k++;
            end
            first = A;
            checks++; if (first === prev || (first !== 8'd0 && first !== 8'd255))
                $display("FAIL tone_edge tp=%0d got %0d after %0d want toggle of %0d", tps[v], first, k, prev); else passed++;
            for (int h = 0; h < 4; h++) begin
                exp = (h % 2 == 0) ? first : 8'd255 - first;
                bad = 0;
                for (int i = 0; i < half; i++) begin
                    if (h != 0 || i != 0) @(negedge clk);
                    if (A !== exp) bad++;
                end
                checks++; if (bad != 0) $display("FAIL tone_half tp=%0d h=%0d got %0d want %0d", tps[v], h, A, exp); else passed++;
            end
        end
        write_reg(4'd7, 8'h3F);
        write_reg(4'd8, 8'h00);
    endtask

    task automatic test_envelope();
        int k;
        write_reg(4'd7, 8'h3F);
        write_reg(4'd11, 8'h01);
        write_reg(4'd12, 8'h00);
        write_reg(4'd8, 8'h10);
        write_reg(4'd13, 8'h0E);
        wait_neg(1);
        checks++; if (A !== 8'd0) $display("FAIL env_start got %0d want 0", A); else passed++;
        k = 0;
        while (A !== 8'd1 && k < 20) begin @(negedge clk); k++; end
        checks++; if (A !== 8'd1) $display("FAIL env_step1 got %0d want 1", A); else passed++;
        for (int s = 1; s < 64; s++) begin
            logic [7:0] exp;
            int bad;
            exp = (s < 32) ? TB_LOG[s] : TB_LOG[31 - (s - 32)];
            bad = 0;
            for (int i = 0; i < 8; i++) begin
                if (s != 1 || i != 0) @(negedge clk);
                if (A !== exp) bad++;
            end
            checks++; if (bad != 0) $display("FAIL env_ramp step=%0d got %0d want %0d", s, A, exp); else passed++;
        end
        wait_neg(100);
        write_reg(4'd13, 8'h0E);
        wait_neg(1);
        checks++; if (A !== 8'd0) $display("FAIL env_restart got %0d want 0", A); else passed++;
        k = 0;
        while (A !== 8'd1 && k < 20) begin @(negedge clk); k++; end
        checks++; if (A !== 8'd1) $display("FAIL env_restart_step got %0d want 1", A); else passed++;
    endtask

    task automatic test_env_shapes();
        logic [7:0] shapes [6] = '{8'h00, 8'h04, 8'h09, 8'h0B, 8'h0D, 8'h0F};
        logic [7:0] finals [6] = '{8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0};
        for (int i = 0; i < 6; i++) begin
            write_reg(4'd13, shapes[i]);
            wait_neg(300);
            checks++; if (A !== finals[i]) $display("FAIL env_shape%02h got %0d want %0d", shapes[i], A, finals[i]); else passed++;
        end
        write_reg(4'd11, 8'h02);
        write_reg(4'd13, 8'h0D);
        wait_neg(300);
        checks++; if (A >= 8'd64) $display("FAIL env_period2_mid got %0d want below 64", A); else passed++;
        wait_neg(300);
        checks++; if (A !== 8'd255) $display("FAIL env_period2_end got %0d want 255", A); else passed++;
        write_reg(4'd8, 8'h00);
        write_reg(4'd11, 8'h01);
    endtask

    task automatic test_readback();
        logic [3:0] ras [6] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd13, 4'd12};
        logic [7:0] rws [6] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA5};
        logic [7:0] rxs [6] = '{8'hFF, 8'h0F, 8'h1F, 8'h1F, 8'h0F, 8'hA5};
        for (int i = 0; i < 6; i++) begin
            write_reg(ras[i], rws[i]);
            addr = ras[i]; #1;
            checks++; if (dout !== rxs[i]) $display("FAIL readback_R%0d got %h want %h", ras[i], dout, rxs[i]); else passed++;
        end
        write_reg(4'd8, 8'h00);
        write_reg(4'd12, 8'h00);
    endtask

    task automatic test_io();
        write_reg(4'd7, 8'h40);
        write_reg(4'd14, 8'h5A);
        addr = 4'd14; #1;
        checks++; if (IOA_out !== 8'h5A) $display("FAIL ioa_out got %h want 5a", IOA_out); else passed++;
        checks++; if (dout !== 8'h5A) $display("FAIL ioa_dout_out got %h want 5a", dout); else passed++;
        IOA_in = 8'h33;
        write_reg(4'd7, 8'h00);
        addr = 4'd14; #1;
        checks++; if (dout !== 8'h33) $display("FAIL ioa_dout_in got %h want 33", dout); else passed++;
        write_reg(4'd7, 8'h80);
        write_reg(4'd15, 8'hA5);
        IOB_in = 8'h11;
        addr = 4'd15; #1;
        checks++; if (IOB_out !== 8'hA5) $display("FAIL iob_out got %h want a5", IOB_out); else passed++;
        checks++; if (dout !== 8'hA5) $display("FAIL iob_dout_out got %h want a5", dout); else passed++;
        write_reg(4'd7, 8'h3F);
        addr = 4'd15; #1;
        checks++; if (dout !== 8'h11) $display("FAIL iob_dout_in got %h want 11", dout); else passed++;
    endtask

    task automatic test_prescale();
        logic sels [3] = '{1'b0, 1'b1, 1'b0};
        int   gaps [3] = '{1, 2, 2};
        int   want [3] = '{10, 10, 5};
        for (int v = 0; v < 3; v++) begin
            int cnt;
            sel = sels[v];
            wait_neg(4);
            cnt = 0;
            for (int i = 0; i < 20; i++) begin
                clk_en = (i % gaps[v] == 0);
                @(negedge clk);
                if (sample === 1'b1) cnt++;
            end
            checks++; if (cnt != want[v]) $display("FAIL prescale sel=%0d gap=%0d got %0d pulses want %0d", sels[v], gaps[v], cnt, want[v]); else passed++;
        end
        sel = 1'b1; clk_en = 1'b1;
    endtask

    task automatic test_midreset();
        write_reg(4'd7, 8'h3F);
        write_reg(4'd8, 8'h0F);
        wait_neg(2);
        checks++; if (A !== 8'd255) $display("FAIL midreset_pre got %0d want 255", A); else passed++;
        reset = 1'b1;
        addr = 4'd8;
        @(negedge clk);
        checks++; if (A !== 8'd0 || sound !== 10'd0) $display("FAIL midreset_out got A=%0d sound=%0d want 0", A, sound); else passed++;
        checks++; if (dout !== 8'd0) $display("FAIL midreset_dout got %h want 00", dout); else passed++;
        checks++; if (IOA_out !== 8'd0) $display("FAIL midreset_io got %h want 00", IOA_out); else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_noise();
        test_fixed_level();
        test_tone();
        test_envelope();
        test_env_shapes();
        test_readback();
        test_io();
        test_prescale();
        test_midreset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
